// File: rtl/sram_pkg.sv
// Shared widths, FSM state encoding and helpers for the SRAM pin-level responder.
package sram_pkg;

  localparam int SRAM_DW = 16;
  localparam int SRAM_AW = 23;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RWAIT,
    RDRIVE
  } sram_state_e;

  function automatic logic [SRAM_DW-1:0] sat_inc(input logic [SRAM_DW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Word array with per-byte write enables and a registered read port; no reset so it maps to block RAM.
module sram_resp_mem
  import sram_pkg::*;
#(
  parameter int DEPTH = 65536,
  parameter int IW    = 16
) (
  input  logic               clk,
  input  logic               wr_hi,
  input  logic               wr_lo,
  input  logic [IW-1:0]      wr_addr,
  input  logic [SRAM_DW-1:0] wr_data,
  input  logic [IW-1:0]      rd_addr,
  output logic [SRAM_DW-1:0] rd_data
);

  logic [SRAM_DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_hi) mem[wr_addr][15:8] <= wr_data[15:8];
    if (wr_lo) mem[wr_addr][7:0]  <= wr_data[7:0];
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Behavioural stand-in for the external 16-bit async SRAM, seen from the chip side of the pins.
module sram_responder
  import sram_pkg::*;
#(
  parameter int DEPTH    = 65536,
  parameter int READ_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SRAM_AW-1:0] addr2sram,
  inout  wire  [SRAM_DW-1:0] data_sram,
  input  logic               cs,
  input  logic               we,
  input  logic               oe,
  input  logic               ub,
  input  logic               lb,
  output logic [15:0]        write_count,
  output logic [15:0]        read_count,
  output logic               proto_err,
  output logic               oor_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SRAM_AW:0] DEPTH_W  = (SRAM_AW + 1)'(DEPTH);
  localparam logic [3:0]       LAT_LAST = 4'(READ_LAT - 1);

  logic               cs_q, we_q, oe_q, ub_q, lb_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [SRAM_DW-1:0] data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q   <= 1'b1;
      we_q   <= 1'b1;
      oe_q   <= 1'b1;
      ub_q   <= 1'b1;
      lb_q   <= 1'b1;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      cs_q   <= cs;
      we_q   <= we;
      oe_q   <= oe;
      ub_q   <= ub;
      lb_q   <= lb;
      addr_q <= addr2sram;
      data_q <= data_sram;
    end
  end

  logic wr_cond, rd_cond, addr_ok;
  assign wr_cond = ~cs_q & ~we_q;
  assign rd_cond = ~cs_q & ~oe_q & we_q;
  assign addr_ok = {1'b0, addr_q} < DEPTH_W;

  sram_state_e        state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [SRAM_AW-1:0] rd_addr, rd_addr_nxt;
  logic               capture, commit, rd_done;

  logic [IW-1:0]      w_addr;
  logic [SRAM_DW-1:0] w_data;
  logic               w_ub, w_lb, w_ok;
  logic               rd_oor;
  logic [SRAM_DW-1:0] mem_q;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rd_addr_nxt = rd_addr;
    capture     = 1'b0;
    commit      = 1'b0;
    rd_done     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_cond) begin
          state_nxt = WRITE;
          capture   = 1'b1;
        end else if (rd_cond) begin
          state_nxt   = RWAIT;
          cnt_nxt     = '0;
          rd_addr_nxt = addr_q;
        end
      end
      WRITE: begin
        if (wr_cond) begin
          capture = 1'b1;
        end else begin
          commit = 1'b1;
          if (rd_cond) begin
            state_nxt   = RWAIT;
            cnt_nxt     = '0;
            rd_addr_nxt = addr_q;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      RWAIT: begin
        if (!rd_cond) begin
          state_nxt = IDLE;
        end else if (addr_q != rd_addr) begin
          cnt_nxt     = '0;
          rd_addr_nxt = addr_q;
        end else if (cnt == LAT_LAST) begin
          state_nxt = RDRIVE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RDRIVE: begin
        if (!rd_cond) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end else if (addr_q != rd_addr) begin
          state_nxt   = RWAIT;
          cnt_nxt     = '0;
          rd_addr_nxt = addr_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_addr     <= '0;
      w_addr      <= '0;
      w_data      <= '0;
      w_ub        <= 1'b1;
      w_lb        <= 1'b1;
      w_ok        <= 1'b0;
      rd_oor      <= 1'b0;
      write_count <= '0;
      read_count  <= '0;
      proto_err   <= 1'b0;
      oor_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_addr <= rd_addr_nxt;
      rd_oor  <= ~addr_ok;
      if (capture) begin
        w_addr <= addr_q[IW-1:0];
        w_data <= data_q;
        w_ub   <= ub_q;
        w_lb   <= lb_q;
        w_ok   <= addr_ok;
      end
      if (commit)  write_count <= sat_inc(write_count);
      if (rd_done) read_count  <= sat_inc(read_count);
      if (~cs_q & ~we_q & ~oe_q) proto_err <= 1'b1;
      if ((wr_cond | rd_cond) & ~addr_ok) oor_err <= 1'b1;
    end
  end

  // Out-of-range writes are dropped here; the count above still advances.
  sram_resp_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .wr_hi   (commit & w_ok & ~w_ub),
    .wr_lo   (commit & w_ok & ~w_lb),
    .wr_addr (w_addr),
    .wr_data (w_data),
    .rd_addr (addr_ok ? addr_q[IW-1:0] : '0),
    .rd_data (mem_q)
  );

  logic [SRAM_DW-1:0] rd_word;
  logic               drv_hi, drv_lo;

  // Raw pins gate the drivers so the bus releases in the same cycle as deassertion.
  assign rd_word = rd_oor ? '0 : mem_q;
  assign drv_hi  = (state == RDRIVE) & ~cs & ~oe & we & ~ub;
  assign drv_lo  = (state == RDRIVE) & ~cs & ~oe & we & ~lb;

  assign data_sram[15:8] = drv_hi ? rd_word[15:8] : 'z;
  assign data_sram[7:0]  = drv_lo ? rd_word[7:0]  : 'z;

endmodule
